fpu_op_sequencer: RTL and testbench

Upstream/downstream companion of the FPU add/sub core. It buffers operand pairs from a producer in a small FIFO and issues each pair to the FPU with a single-cycle start pulse. It waits a fixed guard interval covering worst-case FPU latency, then captures data_out/status_out and presents them on a valid/ready result port. The FPU has no done signal, so this block is the sole source of transaction framing around it.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_op_fifo.sv | 85 ++++++++
 rtl/fpu_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU add/sub core and its operand sequencer:
// word layout, status encoding and the sequencer state encoding.
package fpu_pkg;

    localparam int WORD_W   = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 24;
    localparam int MANT_MSB = 23;

    typedef enum logic [3:0] {
        EXACT     = 4'b0001,
        INEXACT   = 4'b0010,
        OVERFLOW  = 4'b0100,
        UNDERFLOW = 4'b1000
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous operand-pair FIFO with registered pointers and occupancy count;
// the head entry is presented combinationally on rdata.
module fpu_op_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy and compute next pointers and count.
    always_comb begin
        do_push_s = push && (count_q != CNT_W'(DEPTH));
        do_pop_s  = pop && (count_q != CNT_W'(0));

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so a stale pair can never reach the FPU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Frames transactions around the FPU add/sub core: buffers operand pairs, issues a
// start pulse, waits out the worst-case latency and returns the captured result.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 40
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_op_a,
    input  logic [WORD_W-1:0]       in_op_b,
    output logic                    fpu_start,
    output logic [WORD_W-1:0]       fpu_op_a,
    output logic [WORD_W-1:0]       fpu_op_b,
    input  logic [WORD_W-1:0]       fpu_data_in,
    input  logic [3:0]              fpu_status_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_data,
    output logic [3:0]              out_status,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int ENTRY_W = 2 * WORD_W;
    localparam int CNT_W   = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic                fpu_start_q;
    logic                fpu_start_d;
    logic [WORD_W-1:0]   fpu_op_a_q;
    logic [WORD_W-1:0]   fpu_op_a_d;
    logic [WORD_W-1:0]   fpu_op_b_q;
    logic [WORD_W-1:0]   fpu_op_b_d;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic [WORD_W-1:0]   out_data_q;
    logic [WORD_W-1:0]   out_data_d;
    logic [3:0]          out_status_q;
    logic [3:0]          out_status_d;
    logic                busy_q;
    logic                busy_d;

    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_rdata_s;

    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .wdata ({in_op_a, in_op_b}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Next-state and next-output logic for the issue/wait/hold sequence.
    always_comb begin
        state_d      = state_q;
        fpu_start_d  = 1'b0;
        fpu_op_a_d   = fpu_op_a_q;
        fpu_op_b_d   = fpu_op_b_q;
        wait_cnt_d   = wait_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        pop_s        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    fpu_op_a_d  = fifo_rdata_s[ENTRY_W-1:WORD_W];
                    fpu_op_b_d  = fifo_rdata_s[WORD_W-1:0];
                    // Start is registered, so it is high exactly for the ISSUE cycle.
                    fpu_start_d = 1'b1;
                    state_d     = ISSUE;
                end else begin
                    state_d     = IDLE;
                end
            end
            ISSUE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == CNT_W'(0)) begin
                    out_data_d   = fpu_data_in;
                    out_status_d = fpu_status_in;
                    out_valid_d  = 1'b1;
                    state_d      = HOLD;
                end else begin
                    wait_cnt_d   = wait_cnt_q - CNT_W'(1);
                    state_d      = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = HOLD;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fpu_start_q  <= 1'b0;
            fpu_op_a_q   <= '0;
            fpu_op_b_q   <= '0;
            wait_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpu_start_q  <= fpu_start_d;
            fpu_op_a_q   <= fpu_op_a_d;
            fpu_op_b_q   <= fpu_op_b_d;
            wait_cnt_q   <= wait_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            busy_q       <= busy_d;
        end
    end

    assign fpu_start  = fpu_start_q;
    assign fpu_op_a   = fpu_op_a_q;
    assign fpu_op_b   = fpu_op_b_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with a fixed-latency FPU stub.
module tb_fpu_op_sequencer;

    localparam int DEPTH       = 4;
    localparam int WAIT_CYCLES = 40;
    localparam int STUB_DELAY  = 35;
    localparam int LIMIT       = 3000;

    logic                    clock;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_op_a;
    logic [31:0]             in_op_b;
    logic                    fpu_start;
    logic [31:0]             fpu_op_a;
    logic [31:0]             fpu_op_b;
    logic [31:0]             fpu_data_in;
    logic [3:0]              fpu_status_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic [3:0]              out_status;
    logic                    busy;
    logic [$clog2(DEPTH):0]  fifo_count;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          start_cnt  = 0;
    int          res_cnt    = 0;
    int          max_cnt    = 0;
    logic        full_seen  = 1'b0;
    logic        prev_start = 1'b0;
    logic [35:0] sb_q[$];

    fpu_op_sequencer #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op_a       (in_op_a),
        .in_op_b       (in_op_b),
        .fpu_start     (fpu_start),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_status    (out_status),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] stub_data(input logic [31:0] a, input logic [31:0] b);
        return a ^ b ^ 32'h1134_5678;
    endfunction

    function automatic logic [3:0] stub_status(input logic [31:0] a, input logic [31:0] b);
        return 4'b0001 << (a[1:0] ^ b[1:0]);
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Garbage until STUB_DELAY cycles after start is sampled, then the result.
    initial begin : fpu_stub
        logic [31:0] a_s;
        logic [31:0] b_s;
        fpu_data_in   = 32'h0;
        fpu_status_in = 4'h0;
        forever begin
            @(negedge clock);
            if (fpu_start === 1'b1) begin
                a_s           = fpu_op_a;
                b_s           = fpu_op_b;
                fpu_data_in   = ~stub_data(a_s, b_s);
                fpu_status_in = 4'b0000;
                repeat (STUB_DELAY) @(negedge clock);
                fpu_data_in   = stub_data(a_s, b_s);
                fpu_status_in = stub_status(a_s, b_s);
            end
        end
    end

    task automatic monitor_step();
        logic [35:0] expv;
        if (!reset) begin
            sb_q.delete();
            prev_start = 1'b0;
        end else begin
            chk_eq("start_consec", 64'(fpu_start && prev_start), 64'd0);
            if (fpu_start) start_cnt++;
            prev_start = fpu_start;
            chk_eq("count_bound", 64'(int'(fifo_count) <= DEPTH), 64'd1);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (int'(fifo_count) == DEPTH) begin
                full_seen = 1'b1;
                chk_eq("full_in_ready", 64'(in_ready), 64'd0);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({stub_data(in_op_a, in_op_b), stub_status(in_op_a, in_op_b)});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk_eq("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    expv = sb_q.pop_front();
                    chk_eq("res_data", 64'(out_data), 64'(expv[35:4]));
                    chk_eq("res_status", 64'(out_status), 64'(expv[3:0]));
                    res_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor_step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) chk_eq("push_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op_a  = a;
        in_op_b  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int guard = 0;
        while (!out_valid && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) chk_eq(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((sb_q.size() != 0 || busy) && guard < LIMIT) begin
            tick();
            guard++;
        end
        chk_eq(tag, 64'(guard < LIMIT), 64'd1);
    endtask

    task automatic check_reset_vals();
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("rst_fpu_start", 64'(fpu_start), 64'd0);
        chk_eq("rst_fpu_op_a", 64'(fpu_op_a), 64'd0);
        chk_eq("rst_fpu_op_b", 64'(fpu_op_b), 64'd0);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_out_data", 64'(out_data), 64'd0);
        chk_eq("rst_out_status", 64'(out_status), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
    endtask

    initial begin : stimulus
        int n;
        int s0;
        int r0;
        logic seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op_a   = 32'h0;
        in_op_b   = 32'h0;
        out_ready = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b1;
        tick();

        // Single op: latency and bit-exact forwarding
        out_ready = 1'b1;
        s0 = start_cnt;
        push_op(32'h0280_0000, 32'h0180_0000);
        n = 0;
        while (!out_valid && n < LIMIT) begin
            tick();
            n++;
        end
        chk_eq("t1_latency", 64'(n), 64'(WAIT_CYCLES + 2));
        chk_eq("t1_data", 64'(out_data), 64'h1234_5678);
        chk_eq("t1_status", 64'(out_status), 64'h1);
        wait_drain("t1_drain");
        chk_eq("t1_starts", 64'(start_cnt - s0), 64'd1);

        // Fill beyond depth with consumer always ready
        max_cnt   = 0;
        full_seen = 1'b0;
        s0 = start_cnt;
        r0 = res_cnt;
        for (int i = 0; i < 5; i++) push_op($urandom, $urandom);
        wait_drain("t2_drain");
        chk_eq("t2_max_count", 64'(max_cnt), 64'(DEPTH));
        chk_eq("t2_full_seen", 64'(full_seen), 64'd1);
        chk_eq("t2_results", 64'(res_cnt - r0), 64'd5);
        chk_eq("t2_starts", 64'(start_cnt - s0), 64'd5);

        // Backpressure for 100 cycles with one more pair queued
        out_ready = 1'b0;
        push_op($urandom, $urandom);
        wait_valid("t3_valid_timeout");
        push_op($urandom, $urandom);
        for (int i = 0; i < 100; i++) begin
            chk_eq("t3_hold_data", 64'(out_data), 64'(sb_q[0][35:4]));
            chk_eq("t3_hold_status", 64'(out_status), 64'(sb_q[0][3:0]));
            chk_eq("t3_hold_start", 64'(fpu_start), 64'd0);
            chk_eq("t3_hold_valid", 64'(out_valid), 64'd1);
            tick();
        end
        chk_eq("t3_queued", 64'(fifo_count), 64'd1);
        out_ready = 1'b1;
        tick();
        chk_eq("t3_valid_clear", 64'(out_valid), 64'd0);
        chk_eq("t3_start_early", 64'(fpu_start), 64'd0);
        tick();
        chk_eq("t3_reissue", 64'(fpu_start), 64'd1);
        wait_drain("t3_drain");

        // Push coincident with IDLE pop at count 2
        out_ready = 1'b0;
        push_op($urandom, $urandom);
        push_op($urandom, $urandom);
        push_op($urandom, $urandom);
        wait_valid("t4_valid_timeout");
        chk_eq("t4_pre_count", 64'(fifo_count), 64'd2);
        out_ready = 1'b1;
        tick();
        push_op($urandom, $urandom);
        chk_eq("t4_simul_count", 64'(fifo_count), 64'd2);
        chk_eq("t4_simul_start", 64'(fpu_start), 64'd1);
        wait_drain("t4_drain");

        // Reset in WAIT with two pairs queued
        push_op($urandom, $urandom);
        push_op($urandom, $urandom);
        push_op($urandom, $urandom);
        repeat (10) tick();
        chk_eq("t5_pre_count", 64'(fifo_count), 64'd2);
        chk_eq("t5_pre_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (out_valid || fpu_start) seen = 1'b1;
            tick();
        end
        chk_eq("t5_no_activity", 64'(seen), 64'd0);
        chk_eq("t5_post_count", 64'(fifo_count), 64'd0);

        // Pointer wrap over 2*DEPTH+1 single transactions
        s0 = start_cnt;
        r0 = res_cnt;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            push_op($urandom, $urandom);
            wait_drain("t6_drain");
        end
        chk_eq("t6_results", 64'(res_cnt - r0), 64'(2 * DEPTH + 1));
        chk_eq("t6_starts", 64'(start_cnt - s0), 64'(2 * DEPTH + 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
